// File: rtl/rf_bank_read_scheduler_if.sv
// rf_bank_read_scheduler_if
//  Operand-read request / register-file read bus between the issue stage
//  and the banked read scheduler.
//  master : issue side (drives requests, CDB write, flush; sees Stall and reads)
//  slave  : scheduler side
//  Signals: Req_Valid, Src{1,2}_{Valid,Bank,Row}, OCID, WriteValid, WriteBank,
//           Flush -> scheduler; Stall, Rd_En, Rd_Row, Rd_Tag, Conflict_Cnt <- scheduler.
interface rf_bank_read_scheduler_if #(
  parameter int NUM_BANKS = 4,
  parameter int ROW_W     = 3,
  parameter int TAG_W     = 3
);
  localparam int BANK_W = $clog2(NUM_BANKS);

  logic                       Req_Valid;
  logic                       Src1_Valid;
  logic [BANK_W-1:0]          Src1_Bank;
  logic [ROW_W-1:0]           Src1_Row;
  logic                       Src2_Valid;
  logic [BANK_W-1:0]          Src2_Bank;
  logic [ROW_W-1:0]           Src2_Row;
  logic [TAG_W-2:0]           OCID;
  logic                       WriteValid;
  logic [BANK_W-1:0]          WriteBank;
  logic                       Flush;
  logic                       Stall;
  logic [NUM_BANKS-1:0]       Rd_En;
  logic [NUM_BANKS*ROW_W-1:0] Rd_Row;
  logic [NUM_BANKS*TAG_W-1:0] Rd_Tag;
  logic [15:0]                Conflict_Cnt;

  modport master (
    output Req_Valid, Src1_Valid, Src1_Bank, Src1_Row,
           Src2_Valid, Src2_Bank, Src2_Row, OCID,
           WriteValid, WriteBank, Flush,
    input  Stall, Rd_En, Rd_Row, Rd_Tag, Conflict_Cnt
  );

  modport slave (
    input  Req_Valid, Src1_Valid, Src1_Bank, Src1_Row,
           Src2_Valid, Src2_Bank, Src2_Row, OCID,
           WriteValid, WriteBank, Flush,
    output Stall, Rd_En, Rd_Row, Rd_Tag, Conflict_Cnt
  );
endinterface

// File: rtl/rf_bank_read_scheduler.sv
// rf_bank_read_scheduler
//  Queues up to two operand reads per instruction into per-bank FIFOs and
//  issues at most one read per bank per cycle. A CDB write to a bank blocks
//  that bank's read for the cycle; Flush drops everything queued.
//  Ports: clk, rst (async, active-low), bus (rf_bank_read_scheduler_if.slave).

// rf_bank_queue: one bank's circular FIFO of {row, tag} plus its read register.
//  i_s1_we/i_s2_we are already qualified with request acceptance.
module rf_bank_queue #(
  parameter int DEPTH = 4,
  parameter int ROW_W = 3,
  parameter int TAG_W = 3,
  localparam int ENT_W = ROW_W + TAG_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_wr_blk,
  input  logic             i_s1_we,
  input  logic [ENT_W-1:0] i_s1_ent,
  input  logic             i_s2_we,
  input  logic [ENT_W-1:0] i_s2_ent,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_blocked,
  output logic             o_rd_en,
  output logic [ROW_W-1:0] o_rd_row,
  output logic [TAG_W-1:0] o_rd_tag
);
  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_deq;
  logic [CNT_W-1:0] w_n_enq;

  assign w_deq     = (r_cnt != '0) & ~i_wr_blk & ~i_flush;
  assign w_n_enq   = CNT_W'(i_s1_we) + CNT_W'(i_s2_we);
  assign o_blocked = (r_cnt != '0) & i_wr_blk;
  assign o_cnt     = r_cnt;

  // Src1 takes the lower slot when both land in this bank.
  always_ff @(posedge clk) begin
    if (i_s1_we) r_mem[r_wr_ptr] <= i_s1_ent;
    if (i_s2_we) r_mem[r_wr_ptr + PTR_W'(i_s1_we)] <= i_s2_ent;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      o_rd_en  <= 1'b0;
      o_rd_row <= '0;
      o_rd_tag <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      o_rd_en  <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_enq);
      r_cnt    <= r_cnt + w_n_enq - CNT_W'(w_deq);
      o_rd_en  <= w_deq;
      if (w_deq) begin
        r_rd_ptr             <= r_rd_ptr + 1'b1;
        {o_rd_row, o_rd_tag} <= r_mem[r_rd_ptr];
      end
    end
  end
endmodule

module rf_bank_read_scheduler #(
  parameter int NUM_BANKS  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_W      = 3,
  parameter int TAG_W      = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  rf_bank_read_scheduler_if.slave  bus
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W  = CNT_W + 1;
  localparam int ENT_W  = ROW_W + TAG_W;

  logic                 w_accept;
  logic [NUM_BANKS-1:0] w_over, w_blocked;
  logic [ENT_W-1:0]     w_ent1, w_ent2;
  logic [15:0]          r_conflict_cnt;

  assign w_ent1 = {bus.Src1_Row, bus.OCID, 1'b0};
  assign w_ent2 = {bus.Src2_Row, bus.OCID, 1'b1};

  // Stall looks at the current occupancy only; a same-cycle dequeue gives no credit.
  assign bus.Stall = bus.Req_Valid & (|w_over);
  assign w_accept  = bus.Req_Valid & ~bus.Stall & ~bus.Flush;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic             w_s1_hit, w_s2_hit, w_wr_blk;
    logic [1:0]       w_need;
    logic [CNT_W-1:0] w_cnt;

    assign w_s1_hit = bus.Src1_Valid & (bus.Src1_Bank == BANK_W'(b));
    assign w_s2_hit = bus.Src2_Valid & (bus.Src2_Bank == BANK_W'(b));
    assign w_wr_blk = bus.WriteValid & (bus.WriteBank == BANK_W'(b));
    assign w_need   = {1'b0, w_s1_hit} + {1'b0, w_s2_hit};
    assign w_over[b] = (SUM_W'(w_cnt) + SUM_W'(w_need)) > SUM_W'(FIFO_DEPTH);

    rf_bank_queue #(.DEPTH(FIFO_DEPTH), .ROW_W(ROW_W), .TAG_W(TAG_W)) u_q (
      .clk      (clk),
      .rst      (rst),
      .i_flush  (bus.Flush),
      .i_wr_blk (w_wr_blk),
      .i_s1_we  (w_accept & w_s1_hit),
      .i_s1_ent (w_ent1),
      .i_s2_we  (w_accept & w_s2_hit),
      .i_s2_ent (w_ent2),
      .o_cnt    (w_cnt),
      .o_blocked(w_blocked[b]),
      .o_rd_en  (bus.Rd_En[b]),
      .o_rd_row (bus.Rd_Row[b*ROW_W +: ROW_W]),
      .o_rd_tag (bus.Rd_Tag[b*TAG_W +: TAG_W])
    );
  end

  // Only one bank can be write-blocked per cycle, so this is at most +1.
  // Counting continues through Flush; the counter is only cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                          r_conflict_cnt <= '0;
    else if ((|w_blocked) && (r_conflict_cnt != 16'hFFFF)) r_conflict_cnt <= r_conflict_cnt + 16'd1;
  end

  assign bus.Conflict_Cnt = r_conflict_cnt;
endmodule

// File: tb/tb_rf_bank_read_scheduler.sv
module tb_rf_bank_read_scheduler;
  localparam int NB = 4, D = 4, RW = 3, TW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rf_bank_read_scheduler_if #(.NUM_BANKS(NB), .ROW_W(RW), .TAG_W(TW)) bus ();
  rf_bank_read_scheduler #(.NUM_BANKS(NB), .FIFO_DEPTH(D), .ROW_W(RW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_chk = 0, n_fail = 0;

  // Reference: each bank is a plain queue of {row, tag}.
  logic [5:0]       mq [NB][$];
  logic [NB-1:0]    m_en;
  logic [NB*RW-1:0] m_row;
  logic [NB*TW-1:0] m_tag;
  int               m_cc;
  logic             m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.Req_Valid = 0; bus.Src1_Valid = 0; bus.Src1_Bank = 0; bus.Src1_Row = 0;
    bus.Src2_Valid = 0; bus.Src2_Bank = 0; bus.Src2_Row = 0; bus.OCID = 0;
    bus.WriteValid = 0; bus.WriteBank = 0; bus.Flush = 0;
  endtask

  task automatic req(input logic s1v, input logic [1:0] b1, input logic [2:0] r1,
                     input logic s2v, input logic [1:0] b2, input logic [2:0] r2,
                     input logic [1:0] oc);
    bus.Req_Valid = 1; bus.Src1_Valid = s1v; bus.Src1_Bank = b1; bus.Src1_Row = r1;
    bus.Src2_Valid = s2v; bus.Src2_Bank = b2; bus.Src2_Row = r2; bus.OCID = oc;
  endtask

  task automatic model_clear();
    for (int b = 0; b < NB; b++) mq[b].delete();
    m_en = '0; m_row = '0; m_tag = '0; m_cc = 0;
  endtask

  function automatic logic model_stall();
    int need [NB];
    for (int b = 0; b < NB; b++) need[b] = 0;
    if (!bus.Req_Valid) return 1'b0;
    if (bus.Src1_Valid) need[bus.Src1_Bank]++;
    if (bus.Src2_Valid) need[bus.Src2_Bank]++;
    for (int b = 0; b < NB; b++) if (mq[b].size() + need[b] > D) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge();
    logic       blk;
    logic [5:0] e;
    blk = 1'b0;
    for (int b = 0; b < NB; b++)
      if (mq[b].size() != 0 && bus.WriteValid && bus.WriteBank == b) blk = 1'b1;
    if (blk && m_cc < 65535) m_cc++;
    if (bus.Flush) begin
      for (int b = 0; b < NB; b++) mq[b].delete();
      m_en = '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (mq[b].size() != 0 && !(bus.WriteValid && bus.WriteBank == b)) begin
          e = mq[b].pop_front();
          m_en[b] = 1'b1;
          m_row[b*RW +: RW] = e[5:3];
          m_tag[b*TW +: TW] = e[2:0];
        end else m_en[b] = 1'b0;
      end
      if (bus.Req_Valid && !m_stall) begin
        if (bus.Src1_Valid) mq[bus.Src1_Bank].push_back({bus.Src1_Row, bus.OCID, 1'b0});
        if (bus.Src2_Valid) mq[bus.Src2_Bank].push_back({bus.Src2_Row, bus.OCID, 1'b1});
      end
    end
  endtask

  // Entered at a negedge with inputs already driven; leaves at the next negedge.
  task automatic step();
    #1;
    m_stall = model_stall();
    chk("stall", 32'(bus.Stall), 32'(m_stall));
    @(posedge clk);
    model_edge();
    #1;
    chk("rd_en", 32'(bus.Rd_En), 32'(m_en));
    chk("rd_row", 32'(bus.Rd_Row), 32'(m_row));
    chk("rd_tag", 32'(bus.Rd_Tag), 32'(m_tag));
    chk("conflict", 32'(bus.Conflict_Cnt), m_cc);
    @(negedge clk);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic reset_mid();
    #2 rst = 1'b0;
    #1;
    chk("arst_en", 32'(bus.Rd_En), 0);
    chk("arst_row", 32'(bus.Rd_Row), 0);
    chk("arst_tag", 32'(bus.Rd_Tag), 0);
    chk("arst_cc", 32'(bus.Conflict_Cnt), 0);
    model_clear();
    idle();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    idle();
    model_clear();
    #12;
    chk("reset_en", 32'(bus.Rd_En), 0);
    chk("reset_cc", 32'(bus.Conflict_Cnt), 0);
    chk("reset_stall", 32'(bus.Stall), 0);
    @(negedge clk);
    rst = 1'b1;

    // single read, 2-cycle latency
    req(1, 2, 5, 0, 0, 0, 1); step();
    idle(); step();
    chk("t1_en", 32'(bus.Rd_En), 32'h4);
    chk("t1_row", 32'(bus.Rd_Row[8:6]), 5);
    chk("t1_tag", 32'(bus.Rd_Tag[8:6]), 32'h2);
    step();
    chk("t1_en_off", 32'(bus.Rd_En), 0);

    // both sources on one bank: Src1 first
    req(1, 1, 3, 1, 1, 4, 3); step();
    idle(); step();
    chk("t2_first", {bus.Rd_En[1], bus.Rd_Row[5:3], bus.Rd_Tag[5:3]}, {1'b1, 3'd3, 3'b110});
    step();
    chk("t2_second", {bus.Rd_En[1], bus.Rd_Row[5:3], bus.Rd_Tag[5:3]}, {1'b1, 3'd4, 3'b111});
    step();

    // fill bank 0 under a held write, overflow stalls
    for (int i = 0; i < 4; i++) begin
      req(1, 0, 3'(i), 0, 0, 0, 2'(i)); bus.WriteValid = 1; bus.WriteBank = 0; step();
    end
    req(1, 0, 7, 0, 0, 0, 0); bus.WriteValid = 1; bus.WriteBank = 0;
    #1 chk("t3_full_stall", 32'(bus.Stall), 1);
    step();
    idle();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_order", {bus.Rd_En[0], bus.Rd_Row[2:0]}, {1'b1, 3'(i)});
    end
    step();
    chk("t3_drained", 32'(bus.Rd_En), 0);

    // one-cycle write block on bank 3
    reset_mid();
    req(1, 3, 6, 0, 0, 0, 2); step();
    idle(); bus.WriteValid = 1; bus.WriteBank = 3; step();
    chk("t4_blocked", 32'(bus.Rd_En), 0);
    idle(); step();
    chk("t4_late", {bus.Rd_En[3], bus.Rd_Row[11:9]}, {1'b1, 3'd6});
    chk("t4_cc", 32'(bus.Conflict_Cnt), 1);

    // flush with a same-cycle request
    req(1, 0, 1, 1, 1, 2, 0); bus.WriteValid = 1; bus.WriteBank = 0; step();
    req(1, 2, 3, 1, 3, 4, 1); bus.WriteValid = 1; bus.WriteBank = 0; step();
    req(1, 0, 5, 1, 0, 6, 2); bus.Flush = 1; step();
    chk("t5_flush", 32'(bus.Rd_En), 0);
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_quiet", 32'(bus.Rd_En), 0);
    end
    req(1, 1, 2, 0, 0, 0, 3); step();
    idle(); step();
    chk("t5_resume", 32'(bus.Rd_En), 32'h2);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      idle();
      if ($urandom_range(0, 3) != 0) begin
        req($urandom_range(0, 3) != 0, 2'($urandom), 3'($urandom),
            $urandom_range(0, 1) == 1, 2'($urandom), 3'($urandom), 2'($urandom));
      end
      bus.WriteValid = $urandom_range(0, 2) == 0;
      bus.WriteBank  = 2'($urandom);
      bus.Flush      = $urandom_range(0, 49) == 0;
      step();
      if (c == 300) reset_mid();
    end

    // reset while traffic is queued; queues must come back empty
    req(1, 0, 1, 1, 0, 2, 1); bus.WriteValid = 1; bus.WriteBank = 0; step();
    req(1, 2, 3, 1, 2, 4, 2); step();
    reset_mid();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_empty", 32'(bus.Rd_En), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
